// File: rtl/ila_capture_ctrl_pkg.sv
// Shared ILA definitions: capture state encodings and default widths, also used by
// ila_top and the software register map.
package ila_capture_ctrl_pkg;

  localparam int ILA_DATA_WIDTH = 64;
  localparam int ILA_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ILA_IDLE  = 2'd0,
    ILA_ARMED = 2'd1,
    ILA_POST  = 2'd2,
    ILA_DONE  = 2'd3
  } ila_state_e;

endpackage

// File: rtl/ila_capture_ctrl_trig_cmp.sv
// Masked trigger compare: hit when every masked bit of data equals the value bit.
module ila_trig_cmp #(
  parameter int DW = 64
) (
  input  logic [DW-1:0] data,
  input  logic [DW-1:0] mask,
  input  logic [DW-1:0] value,
  output logic          hit
);

  assign hit = ((data ^ value) & mask) == '0;

endmodule

// File: rtl/ila_capture_ctrl.sv
// ILA capture sequencer: circular pre/post-trigger capture into a BRAM, then
// oldest-first readout of the frozen window on software read requests.
module ila_capture_ctrl
  import ila_capture_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = ILA_DATA_WIDTH,
  parameter int ADDR_WIDTH = ILA_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] trig_mask,
  input  logic [DATA_WIDTH-1:0] trig_value,
  input  logic [ADDR_WIDTH-1:0] post_count,
  input  logic                  rd_req,
  output logic                  bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [DATA_WIDTH-1:0] bram_dina,
  output logic                  bram_enb,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [DATA_WIDTH-1:0] bram_doutb,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [1:0]            state,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH:0]   num_valid
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  ila_state_e     state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  post_cnt_q, post_cnt_d;
  logic [AW-1:0]  trig_addr_q, trig_addr_d;
  logic [AW:0]    num_valid_q, num_valid_d;
  logic [AW:0]    fill_cnt_q, fill_cnt_d;
  logic [DW-1:0]  rd_data_q, rd_data_d;
  logic           rd_pend_q, rd_pend_d;
  logic           rd_valid_q, rd_valid_d;

  logic           hit;
  logic           writing;
  logic           rd_fire;
  logic           finish;
  logic [AW-1:0]  wr_ptr_next;
  logic [AW:0]    fill_next;

  ila_trig_cmp #(.DW(DW)) u_trig_cmp (
    .data  (data_in),
    .mask  (trig_mask),
    .value (trig_value),
    .hit   (hit)
  );

  assign writing     = (state_q == ILA_ARMED) || (state_q == ILA_POST);
  assign rd_fire     = (state_q == ILA_DONE) && rd_req && !arm;
  assign wr_ptr_next = wr_ptr_q + 1'b1;
  assign fill_next   = (fill_cnt_q == DEPTH) ? DEPTH : fill_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    num_valid_d = num_valid_q;
    fill_cnt_d  = fill_cnt_q;
    finish      = 1'b0;
    // Read data is one cycle behind the port-B request; in-flight reads survive arm.
    rd_pend_d   = rd_fire;
    rd_valid_d  = rd_pend_q;
    rd_data_d   = rd_pend_q ? bram_doutb : rd_data_q;

    if (arm) begin
      state_d    = ILA_ARMED;
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
    end else begin
      if (writing) begin
        wr_ptr_d   = wr_ptr_next;
        fill_cnt_d = fill_next;
      end
      case (state_q)
        ILA_ARMED: begin
          if (hit) begin
            trig_addr_d = wr_ptr_q;
            if (post_count == '0) begin
              finish = 1'b1;
            end else begin
              post_cnt_d = post_count;
              state_d    = ILA_POST;
            end
          end
        end
        ILA_POST: begin
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == AW'(1)) finish = 1'b1;
        end
        ILA_DONE: begin
          if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
        end
        default: ;
      endcase
      // Once wrapped, the oldest sample sits just past the final write.
      if (finish) begin
        state_d     = ILA_DONE;
        num_valid_d = fill_next;
        rd_ptr_d    = (fill_next == DEPTH) ? wr_ptr_next : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ILA_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      num_valid_q <= '0;
      fill_cnt_q  <= '0;
      rd_data_q   <= '0;
      rd_pend_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      num_valid_q <= num_valid_d;
      fill_cnt_q  <= fill_cnt_d;
      rd_data_q   <= rd_data_d;
      rd_pend_q   <= rd_pend_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign bram_wea   = writing;
  assign bram_addra = wr_ptr_q;
  assign bram_dina  = data_in;
  assign bram_enb   = rd_fire;
  assign bram_addrb = rd_ptr_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign state      = state_q;
  assign trig_addr  = trig_addr_q;
  assign num_valid  = num_valid_q;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Bench for ila_capture_ctrl: directed capture table, hand-written corner sequences
// and randomized captures checked against a sample-history model.
module tb_ila_capture_ctrl;
  import ila_capture_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_in, trig_mask, trig_value;
  logic        arm, rd_req;
  logic [7:0]  post_count;
  logic        bram_wea, bram_enb, rd_valid;
  logic [7:0]  bram_addra, bram_addrb, trig_addr;
  logic [63:0] bram_dina, bram_doutb, rd_data;
  logic [1:0]  state;
  logic [8:0]  num_valid;

  logic [63:0] mem [256];
  logic [63:0] stim [1024];
  logic [63:0] exp_q [$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  ila_capture_ctrl dut (
    .clk(clk), .rst(rst), .data_in(data_in), .arm(arm),
    .trig_mask(trig_mask), .trig_value(trig_value), .post_count(post_count),
    .rd_req(rd_req), .bram_wea(bram_wea), .bram_addra(bram_addra),
    .bram_dina(bram_dina), .bram_enb(bram_enb), .bram_addrb(bram_addrb),
    .bram_doutb(bram_doutb), .rd_data(rd_data), .rd_valid(rd_valid),
    .state(state), .trig_addr(trig_addr), .num_valid(num_valid)
  );

  // clock / BRAM model
  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_wea) mem[bram_addra] <= bram_dina;
    if (bram_enb) bram_doutb <= mem[bram_addrb];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"},     64'(state), 64'(ILA_IDLE));
    check({tag, "_wea"},       64'(bram_wea), 64'd0);
    check({tag, "_addra"},     64'(bram_addra), 64'd0);
    check({tag, "_enb"},       64'(bram_enb), 64'd0);
    check({tag, "_addrb"},     64'(bram_addrb), 64'd0);
    check({tag, "_trig_addr"}, 64'(trig_addr), 64'd0);
    check({tag, "_num_valid"}, 64'(num_valid), 64'd0);
    check({tag, "_rd_valid"},  64'(rd_valid), 64'd0);
    check({tag, "_rd_data"},   rd_data, 64'd0);
  endtask

  task automatic pulse_arm();
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
  endtask

  // drive stim[k] on the k-th armed/post cycle until DONE
  task automatic capture(input logic [63:0] mask, input logic [63:0] value, input logic [7:0] post,
                         input int exp_writes, input logic [7:0] exp_trig, input logic [8:0] exp_nv);
    int k;
    k = 0;
    trig_mask = mask; trig_value = value; post_count = post;
    pulse_arm();
    while (state != 2'(ILA_DONE) && k < 1000) begin
      data_in = stim[k];
      k++;
      @(negedge clk);
    end
    check("writes_to_done", 64'(k), 64'(exp_writes));
    check("state_done", 64'(state), 64'(ILA_DONE));
    check("trig_addr", 64'(trig_addr), 64'(exp_trig));
    check("num_valid", 64'(num_valid), 64'(exp_nv));
  endtask

  // n back-to-back requests; results compared against exp_q
  task automatic read_window(input int n, input logic [7:0] first_addr);
    int issued, got, cyc;
    issued = 0; got = 0; cyc = 0;
    while (got < n && cyc < n + 20) begin
      @(negedge clk);
      if (rd_valid) begin
        got++;
        if (exp_q.size() == 0) check("rd_extra", 64'd1, 64'd0);
        else check("rd_data", rd_data, exp_q.pop_front());
      end
      rd_req = (issued < n);
      #1;
      if (issued == 0 && rd_req) begin
        check("first_addrb", 64'(bram_addrb), 64'(first_addr));
        check("first_enb", 64'(bram_enb), 64'd1);
      end
      if (rd_req) issued++;
      cyc++;
    end
    rd_req = 1'b0;
    check("rd_valid_count", 64'(got), 64'(n));
  endtask

  function automatic int first_hit(input logic [63:0] m, input logic [63:0] v);
    for (int i = 0; i < 1024; i++)
      if (((stim[i] ^ v) & m) == 64'd0) return i;
    return -1;
  endfunction

  typedef struct {
    logic [63:0] mask;
    logic [63:0] value;
    logic [7:0]  post;
    int          exp_writes;
    logic [7:0]  exp_trig;
    logic [8:0]  exp_nv;
    logic [63:0] exp_first;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int vcount;
    vecs[0] = '{64'hFF,   64'h55,  8'd3,   89,  8'h55, 9'h59, 64'd0};
    vecs[1] = '{64'h0,    64'h0,   8'd0,   1,   8'h00, 9'd1,  64'd0};
    vecs[2] = '{64'hFFFF, 64'h12C, 8'd10,  311, 8'h2C, 9'd256, 64'd55};
    vecs[3] = '{64'hF,    64'h3,   8'd255, 259, 8'h03, 9'd256, 64'd3};

    rst = 1'b1; arm = 1'b0; rd_req = 1'b0; data_in = '0;
    trig_mask = '0; trig_value = '0; post_count = '0;
    #3;
    check_reset("reset");
    @(negedge clk); rst = 1'b0;

    // directed table with counter data
    for (int i = 0; i < 1024; i++) stim[i] = 64'(i);
    for (int v = 0; v < 4; v++) begin
      capture(vecs[v].mask, vecs[v].value, vecs[v].post,
              vecs[v].exp_writes, vecs[v].exp_trig, vecs[v].exp_nv);
      exp_q.delete();
      for (int i = 0; i < int'(vecs[v].exp_nv); i++) exp_q.push_back(vecs[v].exp_first + 64'(i));
      read_window(int'(vecs[v].exp_nv), vecs[v].exp_first[7:0]);
    end

    // full window fully read: next read wraps to the oldest; arm must not swallow it
    @(negedge clk); rd_req = 1'b1;
    @(negedge clk); rd_req = 1'b0; arm = 1'b1;
    trig_mask = '1; trig_value = 64'h1; data_in = 64'h0;
    @(negedge clk); arm = 1'b0;
    vcount = 0;
    for (int c = 0; c < 3; c++) begin
      if (rd_valid) begin
        vcount++;
        check("inflight_data", rd_data, 64'd3);
      end
      @(negedge clk);
    end
    check("inflight_count", 64'(vcount), 64'd1);
    check("armed_after_rearm", 64'(state), 64'(ILA_ARMED));

    // rd_req while ARMED is ignored
    rd_req = 1'b1; #1;
    check("armed_enb", 64'(bram_enb), 64'd0);
    @(negedge clk); rd_req = 1'b0;
    vcount = 0;
    for (int c = 0; c < 3; c++) begin
      if (rd_valid) vcount++;
      @(negedge clk);
    end
    check("armed_rd_valid", 64'(vcount), 64'd0);

    // arm during POST, then arm colliding with a hit
    trig_mask = 64'hFF; trig_value = 64'h05; post_count = 8'd20;
    pulse_arm();
    for (int k = 0; k < 10; k++) begin data_in = stim[k]; @(negedge clk); end
    check("post_state", 64'(state), 64'(ILA_POST));
    check("post_trig_addr", 64'(trig_addr), 64'h05);
    arm = 1'b1; @(negedge clk); arm = 1'b0; data_in = 64'h0;
    check("rearm_state", 64'(state), 64'(ILA_ARMED));
    check("rearm_addra", 64'(bram_addra), 64'd0);
    for (int k = 0; k < 3; k++) @(negedge clk);
    check("pre_collide_addra", 64'(bram_addra), 64'd3);
    post_count = 8'd0; data_in = 64'h05; arm = 1'b1;
    @(negedge clk); arm = 1'b0; data_in = 64'h0;
    check("collide_state", 64'(state), 64'(ILA_ARMED));
    check("collide_addra", 64'(bram_addra), 64'd0);
    check("collide_trig_addr", 64'(trig_addr), 64'h05);

    // asynchronous reset in the middle of POST
    trig_mask = 64'hFF; trig_value = 64'h10; post_count = 8'd50;
    pulse_arm();
    for (int k = 0; k < 21; k++) begin data_in = stim[k]; @(negedge clk); end
    check("pre_rst_state", 64'(state), 64'(ILA_POST));
    #2 rst = 1'b1;
    #1 check_reset("async_rst");
    @(negedge clk); rst = 1'b0;

    // randomized captures against the sample-history model
    for (int t = 0; t < 8; t++) begin
      logic [63:0] m, v, d;
      int tk, k, total, nv;
      logic [7:0] pc;
      m = '0;
      for (int b = 0, nb = $urandom_range(0, 5); b < nb; b++) m[$urandom_range(0, 63)] = 1'b1;
      v = {$urandom, $urandom};
      tk = (m == 0) ? 0 : $urandom_range(0, 600);
      for (int i = 0; i < 1024; i++) begin
        d = {$urandom, $urandom};
        if (i < tk && ((d ^ v) & m) == 64'd0) d = d ^ (m & ~(m - 64'd1));
        if (i == tk) d = (d & ~m) | (v & m);
        stim[i] = d;
      end
      pc = (t % 2 == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
      k = first_hit(m, v);
      total = k + 1 + int'(pc);
      nv = (total > 256) ? 256 : total;
      exp_q.delete();
      for (int i = total - nv; i < total; i++) exp_q.push_back(stim[i]);
      capture(m, v, pc, total, 8'(k), 9'(nv));
      read_window(nv, 8'(total - nv));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
